// File: rtl/pipelined_mac_array.sv
// ---------------------------------------------------------------------------
// pipelined_mac_array
//
// Pipelined, multi-lane signed multiply-accumulate unit. Each accepted beat
// carries LANES signed operand pairs. These are multiplied (S1), reduced by an
// adder tree (S2) and accumulated across beats (S3) until a beat flagged
// last. A per-vector bias in_c is folded in on the first beat. The finished
// dot product passes through an output register with a valid/ready handshake.
// Optional saturation clamps results to the OW signed range.
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   rst        asynchronous, active-high reset
//   in_valid   beat valid
//   in_ready   beat accepted when in_valid && in_ready (global enable)
//   in_a       LANES signed BITWIDTH lanes, lane i at [i*BITWIDTH +: BITWIDTH]
//   in_b       LANES signed BITWIDTH lanes, same packing
//   in_c       OW-bit signed bias, used only on the first beat of a vector
//   in_last    marks the final beat of a vector
//   out_valid  result valid
//   out_ready  result consumed when out_valid && out_ready
//   out_data   OW-bit signed dot product plus bias
//   out_ovf    result exceeded the OW signed range (clamped or wrapped)
//   out_beats  number of beats in the vector, saturating at 2^CNTW-1
// ---------------------------------------------------------------------------
module pipelined_mac_array #(
  parameter int BITWIDTH                 = 8,
  parameter int IS_BITWIDTH_DOUBLE_SCALE = 1,
  parameter int LANES                    = 4,
  parameter int ACC_GUARD                = 8,
  parameter int SATURATE                 = 1,
  parameter int CNTW                     = 16,
  localparam int OW = BITWIDTH * (IS_BITWIDTH_DOUBLE_SCALE + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*BITWIDTH-1:0] in_a,
  input  logic [LANES*BITWIDTH-1:0] in_b,
  input  logic [OW-1:0]             in_c,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OW-1:0]             out_data,
  output logic                      out_ovf,
  output logic [CNTW-1:0]           out_beats
);

  localparam int PW   = 2 * BITWIDTH;
  localparam int LG   = (LANES > 1) ? $clog2(LANES) : 0;
  localparam int ACCW = PW + LG + ACC_GUARD;

  localparam logic [OW-1:0] OUT_MAX = {1'b0, {(OW-1){1'b1}}};
  localparam logic [OW-1:0] OUT_MIN = {1'b1, {(OW-1){1'b0}}};

  // The whole pipeline freezes only while a result is held unconsumed.
  logic en;
  logic accept;

  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;
  assign accept   = in_valid && en;

  // Lane multipliers; operands widened first so the product is full width.
  logic signed [PW-1:0] prod [LANES];

  for (genvar g = 0; g < LANES; g++) begin : g_mul
    assign prod[g] = PW'($signed(in_a[g*BITWIDTH +: BITWIDTH])) *
                     PW'($signed(in_b[g*BITWIDTH +: BITWIDTH]));
  end

  // Tracks whether the next accepted beat opens a new vector.
  logic first_trk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_trk <= 1'b1;
    end else if (accept) begin
      first_trk <= in_last;
    end
  end

  // Stage S1: products, flags and the sign-extended bias.
  logic                   s1_valid;
  logic                   s1_first;
  logic                   s1_last;
  logic signed [ACCW-1:0] s1_bias;
  logic signed [PW-1:0]   s1_prod [LANES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_bias  <= '0;
      for (int i = 0; i < LANES; i++) begin
        s1_prod[i] <= '0;
      end
    end else if (en) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_first <= first_trk;
        s1_last  <= in_last;
        for (int i = 0; i < LANES; i++) begin
          s1_prod[i] <= prod[i];
        end
        if (first_trk) begin
          s1_bias <= ACCW'($signed(in_c));
        end
      end
    end
  end

  // Binary adder tree held in heap order: leaves at LANES..2*LANES-1,
  // node k sums nodes 2k and 2k+1, and the root lands at index 1.
  logic signed [ACCW-1:0] tree_sum;

  always_comb begin
    logic signed [ACCW-1:0] node [1:2*LANES-1];
    for (int i = 0; i < LANES; i++) begin
      node[LANES+i] = ACCW'(s1_prod[i]);
    end
    for (int k = LANES - 1; k >= 1; k--) begin
      node[k] = node[2*k] + node[2*k+1];
    end
    tree_sum = node[1];
  end

  // Stage S2: registered lane sum plus the flags and bias.
  logic                   s2_valid;
  logic                   s2_first;
  logic                   s2_last;
  logic signed [ACCW-1:0] s2_bias;
  logic signed [ACCW-1:0] s2_sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_first <= 1'b0;
      s2_last  <= 1'b0;
      s2_bias  <= '0;
      s2_sum   <= '0;
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_first <= s1_first;
      s2_last  <= s1_last;
      s2_bias  <= s1_bias;
      s2_sum   <= tree_sum;
    end
  end

  // Accumulate and convert. A first beat starts from the bias instead of
  // the running sum, so a single-beat vector needs no special case.
  logic signed [ACCW-1:0] acc;
  logic [CNTW-1:0]        beat_cnt;
  logic signed [ACCW-1:0] acc_next;
  logic                   fits;
  logic [OW-1:0]          conv_data;
  logic                   conv_ovf;
  logic [CNTW-1:0]        beats_next;

  always_comb begin
    acc_next  = (s2_first ? s2_bias : acc) + s2_sum;
    // In range exactly when every bit above the OW sign bit copies it.
    fits      = (&acc_next[ACCW-1:OW-1]) || !(|acc_next[ACCW-1:OW-1]);
    conv_data = acc_next[OW-1:0];
    conv_ovf  = 1'b0;
    if (!fits) begin
      conv_ovf = 1'b1;
      if (SATURATE != 0) begin
        conv_data = acc_next[ACCW-1] ? OUT_MIN : OUT_MAX;
      end
    end
    if (s2_first) begin
      beats_next = CNTW'(1);
    end else if (&beat_cnt) begin
      beats_next = beat_cnt;
    end else begin
      beats_next = beat_cnt + 1'b1;
    end
  end

  // Stage S3: accumulator, beat counter and the finished-result register.
  logic            s3_valid;
  logic [OW-1:0]   s3_data;
  logic            s3_ovf;
  logic [CNTW-1:0] s3_beats;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      beat_cnt <= '0;
      s3_valid <= 1'b0;
      s3_data  <= '0;
      s3_ovf   <= 1'b0;
      s3_beats <= '0;
    end else if (en) begin
      s3_valid <= s2_valid && s2_last;
      if (s2_valid) begin
        beat_cnt <= beats_next;
        if (s2_last) begin
          acc      <= '0;
          s3_data  <= conv_data;
          s3_ovf   <= conv_ovf;
          s3_beats <= beats_next;
        end else begin
          acc <= acc_next;
        end
      end
    end
  end

  // Output register. When the held result is consumed and nothing new
  // arrives, out_valid drops; otherwise it reloads with the new result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
      out_beats <= '0;
    end else if (en) begin
      out_valid <= s3_valid;
      if (s3_valid) begin
        out_data  <= s3_data;
        out_ovf   <= s3_ovf;
        out_beats <= s3_beats;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_mac_array.sv
// ---------------------------------------------------------------------------
// tb_pipelined_mac_array
//
// Self-checking bench for pipelined_mac_array. Two instances share all
// inputs: one saturating, one wrapping. A reference model computes each
// vector's dot product with plain integer arithmetic and queues the expected
// results, which are compared whenever a result is consumed. Directed steps
// cover latency, multi-beat vectors, overflow, backpressure, reset
// mid-vector and streaming, followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_pipelined_mac_array;

  localparam int BW    = 8;
  localparam int LANES = 4;
  localparam int OW    = 16;
  localparam int CNTW  = 16;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*BW-1:0]    in_a;
  logic [LANES*BW-1:0]    in_b;
  logic [OW-1:0]          in_c;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [OW-1:0]          out_data;
  logic                   out_ovf;
  logic [CNTW-1:0]        out_beats;

  logic                   w_in_ready;
  logic                   w_out_valid;
  logic [OW-1:0]          w_out_data;
  logic                   w_out_ovf;
  logic [CNTW-1:0]        w_out_beats;

  always #5 clk = ~clk;

  pipelined_mac_array #(.SATURATE(1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf), .out_beats(out_beats)
  );

  pipelined_mac_array #(.SATURATE(0)) dut_wrap (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(w_in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_last(in_last),
    .out_valid(w_out_valid), .out_ready(out_ready),
    .out_data(w_out_data), .out_ovf(w_out_ovf), .out_beats(w_out_beats)
  );

  typedef struct {
    logic [OW-1:0]   dsat;
    logic [OW-1:0]   dwrap;
    logic            ovf;
    logic [CNTW-1:0] beats;
  } exp_t;

  int     n_tests = 0;
  int     n_fail  = 0;
  int     n_delivered = 0;

  // Reference model state for the vector currently being assembled.
  bit     m_first = 1'b1;
  longint m_sum   = 0;
  int     m_beats = 0;
  exp_t   exp_q[$];

  // Values currently driven on the beat inputs.
  int     a_l [LANES];
  int     b_l [LANES];
  int     cur_c;
  bit     cur_last;

  // Observations from the latest pre-edge sample.
  bit            s_in_ready;
  bit            prev_stall = 1'b0;
  logic [OW-1:0] prev_data;
  logic          prev_ovf;
  logic [CNTW-1:0] prev_beats;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic set_beat(input bit v, input int c, input bit last);
    for (int i = 0; i < LANES; i++) begin
      in_a[i*BW +: BW] = a_l[i][BW-1:0];
      in_b[i*BW +: BW] = b_l[i][BW-1:0];
    end
    in_c     = c[OW-1:0];
    in_last  = last;
    in_valid = v;
    cur_c    = c;
    cur_last = last;
  endtask

  task automatic fill(input int a0, input int a1, input int a2, input int a3,
                      input int b0, input int b1, input int b2, input int b3);
    a_l[0] = a0; a_l[1] = a1; a_l[2] = a2; a_l[3] = a3;
    b_l[0] = b0; b_l[1] = b1; b_l[2] = b2; b_l[3] = b3;
  endtask

  task automatic randomize_lanes();
    for (int i = 0; i < LANES; i++) begin
      a_l[i] = int'($urandom_range(0, 255)) - 128;
      b_l[i] = int'($urandom_range(0, 255)) - 128;
    end
  endtask

  // Reference model: one accepted beat, computed from plain arithmetic.
  task automatic model_accept();
    longint dot;
    exp_t   e;
    dot = 0;
    for (int i = 0; i < LANES; i++) begin
      dot += longint'(a_l[i]) * longint'(b_l[i]);
    end
    if (m_first) begin
      m_sum   = longint'(cur_c);
      m_beats = 0;
    end
    m_sum += dot;
    if (m_beats < 65535) m_beats++;
    m_first = cur_last;
    if (cur_last) begin
      e.dwrap = m_sum[OW-1:0];
      e.beats = m_beats[CNTW-1:0];
      if (m_sum > 64'sd32767) begin
        e.dsat = 16'h7fff;
        e.ovf  = 1'b1;
      end else if (m_sum < -64'sd32768) begin
        e.dsat = 16'h8000;
        e.ovf  = 1'b1;
      end else begin
        e.dsat = m_sum[OW-1:0];
        e.ovf  = 1'b0;
      end
      exp_q.push_back(e);
    end
  endtask

  // One clock cycle: sample just before the edge, score any handshake,
  // update the model on acceptance, then advance past the edge.
  task automatic cycle(output bit accepted);
    bit   consumed;
    exp_t e;
    #1;
    accepted   = in_valid && in_ready;
    consumed   = out_valid && out_ready;
    s_in_ready = in_ready;
    check("in_ready_rule", in_ready, !(out_valid && !out_ready));
    check("wrap_sync", {w_out_valid, w_in_ready}, {out_valid, in_ready});
    if (prev_stall) begin
      check("hold_valid", out_valid, 1'b1);
      check("hold_data", out_data, prev_data);
      check("hold_ovf", out_ovf, prev_ovf);
      check("hold_beats", out_beats, prev_beats);
    end
    if (consumed) begin
      check("result_expected", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("data_sat", out_data, e.dsat);
        check("data_wrap", w_out_data, e.dwrap);
        check("ovf_sat", out_ovf, e.ovf);
        check("ovf_wrap", w_out_ovf, e.ovf);
        check("beats", out_beats, e.beats);
        check("beats_wrap", w_out_beats, e.beats);
        n_delivered++;
      end
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    prev_ovf   = out_ovf;
    prev_beats = out_beats;
    if (accepted) model_accept();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit acc;
    set_beat(1'b0, 0, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) cycle(acc);
  endtask

  task automatic wait_valid(input string tag);
    bit acc;
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      cycle(acc);
      n++;
    end
    check(tag, out_valid, 1'b1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bit acc;
    int lat;
    int k;
    int n_stall;
    int base;
    int run;
    int max_run;
    int len;
    int tries;

    rst       = 1'b1;
    out_ready = 1'b1;
    fill(0, 0, 0, 0, 0, 0, 0, 0);
    set_beat(1'b0, 0, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    // Reset values.
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 16'd0);
    check("rst_out_ovf", out_ovf, 1'b0);
    check("rst_out_beats", out_beats, 16'd0);
    check("rst_in_ready", in_ready, 1'b1);
    rst = 1'b0;

    // Single beat: exact latency of three edges after acceptance.
    fill(1, 2, 3, 4, 5, 6, 7, 8);
    set_beat(1'b1, 10, 1'b1);
    cycle(acc);
    check("t1_accepted", acc, 1'b1);
    set_beat(1'b0, 0, 1'b0);
    check("t1_not_early", out_valid, 1'b0);
    lat = 0;
    while (!out_valid && lat < 10) begin
      cycle(acc);
      lat++;
    end
    check("t1_latency", lat, 3);
    check("t1_data", out_data, 16'd80);
    check("t1_ovf", out_ovf, 1'b0);
    check("t1_beats", out_beats, 16'd1);
    idle(3);

    // Two-beat vector; the bias on the second beat is ignored.
    fill(3, 3, 3, 3, 3, 3, 3, 3);
    set_beat(1'b1, 1, 1'b0);
    cycle(acc);
    fill(-3, -3, -3, -3, 1, 1, 1, 1);
    set_beat(1'b1, 99, 1'b1);
    cycle(acc);
    set_beat(1'b0, 0, 1'b0);
    wait_valid("t2_valid");
    check("t2_data", out_data, 16'd25);
    check("t2_beats", out_beats, 16'd2);
    idle(3);

    // Positive overflow: clamp versus wrap.
    fill(-128, -128, -128, -128, -128, -128, -128, -128);
    set_beat(1'b1, 0, 1'b1);
    cycle(acc);
    set_beat(1'b0, 0, 1'b0);
    wait_valid("t3_valid");
    check("t3_sat_data", out_data, 16'h7fff);
    check("t3_sat_ovf", out_ovf, 1'b1);
    check("t3_wrap_data", w_out_data, 16'h0000);
    check("t3_wrap_ovf", w_out_ovf, 1'b1);
    idle(3);

    // Negative overflow: -65024 clamps to 0x8000 and wraps to 0x0200.
    fill(-128, -128, -128, -128, 127, 127, 127, 127);
    set_beat(1'b1, 0, 1'b1);
    cycle(acc);
    set_beat(1'b0, 0, 1'b0);
    wait_valid("t3n_valid");
    check("t3n_sat_data", out_data, 16'h8000);
    check("t3n_wrap_data", w_out_data, 16'h0200);
    check("t3n_ovf", out_ovf, 1'b1);
    idle(3);

    // Backpressure: eight results 1..8 with out_ready low for five cycles.
    k       = 1;
    n_stall = 0;
    base    = n_delivered;
    for (int cyc = 0; cyc < 30; cyc++) begin
      out_ready = !(cyc >= 5 && cyc < 10);
      if (k <= 8) begin
        fill(k, 0, 0, 0, 1, 0, 0, 0);
        set_beat(1'b1, 0, 1'b1);
      end else begin
        set_beat(1'b0, 0, 1'b0);
      end
      cycle(acc);
      if (acc) k++;
      if (!s_in_ready) n_stall++;
    end
    check("t4_stall_cycles", n_stall, 5);
    check("t4_delivered", n_delivered - base, 8);
    check("t4_queue_empty", exp_q.size(), 0);
    idle(2);

    // Reset in the middle of a three-beat vector.
    fill(1, 1, 1, 1, 1, 2, 3, 4);
    set_beat(1'b1, 0, 1'b0);
    cycle(acc);
    cycle(acc);
    set_beat(1'b0, 0, 1'b0);
    rst = 1'b1;
    #1;
    check("t5_valid_in_reset", out_valid, 1'b0);
    @(posedge clk);
    #1;
    check("t5_valid_in_reset_edge", out_valid, 1'b0);
    rst = 1'b0;
    m_first    = 1'b1;
    exp_q.delete();
    prev_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle(acc);
      check("t5_valid_after_reset", out_valid, 1'b0);
    end
    fill(7, 0, 0, 0, 1, 0, 0, 0);
    set_beat(1'b1, 0, 1'b1);
    cycle(acc);
    set_beat(1'b0, 0, 1'b0);
    wait_valid("t5_valid");
    check("t5_data", out_data, 16'd7);
    check("t5_beats", out_beats, 16'd1);
    idle(3);

    // Streaming: sixteen back-to-back single-beat vectors.
    run     = 0;
    max_run = 0;
    base    = n_delivered;
    out_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      if (i < 16) begin
        randomize_lanes();
        set_beat(1'b1, int'($urandom_range(0, 65535)) - 32768, 1'b1);
      end else begin
        set_beat(1'b0, 0, 1'b0);
      end
      cycle(acc);
      check("t6_in_ready", s_in_ready, 1'b1);
      if (out_valid) begin
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
    end
    check("t6_valid_run", max_run, 16);
    check("t6_delivered", n_delivered - base, 16);

    // Randomized vectors with bubbles, ignored inputs and random backpressure.
    for (int v = 0; v < 40; v++) begin
      len = int'($urandom_range(1, 4));
      for (int bt = 0; bt < len; bt++) begin
        if ($urandom_range(0, 3) == 0) begin
          set_beat(1'b0, int'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));
          out_ready = ($urandom_range(0, 4) != 0);
          cycle(acc);
        end
        randomize_lanes();
        set_beat(1'b1, int'($urandom_range(0, 65535)) - 32768, bt == len - 1);
        tries = 0;
        do begin
          out_ready = ($urandom_range(0, 4) != 0);
          cycle(acc);
          tries++;
        end while (!acc && tries < 50);
        check("t7_accept", acc, 1'b1);
      end
    end
    idle(10);
    check("t7_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_mac_array.md
# pipelined_mac_array

Parametrised, pipelined, multi-lane signed multiply-accumulate unit for the matrix-multiply datapath. It is the sequential successor to the combinational a*b+c cell. Each accepted beat carries LANES operand pairs, which are multiplied and reduced, then accumulated across beats until a beat flagged last. The bias in_c is added once per vector, and the finished dot product is emitted through a valid/ready output with optional saturation.

## Interface
- BITWIDTH, 8: signed width of each a/b lane element.
- IS_BITWIDTH_DOUBLE_SCALE, 1: output and bias width OW = BITWIDTH*(IS_BITWIDTH_DOUBLE_SCALE+1).
- LANES, 4: parallel multiplier lanes; power of two, ≥1.
- ACC_GUARD, 8: extra accumulator guard bits.
- SATURATE, 1: 1 = clamp result to OW signed range; 0 = two's-complement truncate.
- CNTW, 16: width of beat counter output.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- in_a  in  LANES*BITWIDTH  signed lanes; lane i at [i*BITWIDTH +: BITWIDTH].
- in_b  in  LANES*BITWIDTH  signed lanes, same packing.
- in_c  in  OW  signed bias; sampled only on the first beat of a vector.
- in_last  in  1  marks the final beat of a vector.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid && out_ready.
- out_data  out  OW  signed dot product + bias.
- out_ovf  out  1  result exceeded the OW signed range (clamped or wrapped).
- out_beats  out  CNTW  beats in this vector; saturates at 2^CNTW-1.

## Operation
- Internal accumulator width ACCW = 2*BITWIDTH + log2(LANES) + ACC_GUARD.
- All products, sums and bias are sign-extended to ACCW.
- Global enable en = !(out_valid && !out_ready); in_ready = en.
- Every pipeline register advances only when en is high.
- Stage S1 registers:
  - LANES products, 2*BITWIDTH signed each.
  - first and last flags, and a valid bit.
  - The bias, sign-extended from in_c.
- Stage S2: adder-tree sum of the S1 products into a registered lane_sum, plus the flags and bias.
- Stage S3 accumulate: acc_next = (first ? bias : acc) + lane_sum.
  - If last: result = acc_next and acc is cleared.
  - Otherwise: acc <= acc_next.
- first tracker: an internal flag set at reset and after each accepted last beat; cleared by any accepted non-last beat.
- A single-beat vector (first and last together) is legal.
- Output conversion:
  - If acc_next fits in OW signed range: out_data = acc_next[OW-1:0], out_ovf=0.
  - Else with SATURATE=1: out_data = 2^(OW-1)-1 or -2^(OW-1) by sign, out_ovf=1.
  - Else with SATURATE=0: low OW bits, out_ovf=1.
- Beat counter: counts valid beats reaching S3, loads 1 on a first beat, and is copied to out_beats with the result.
- Accumulator overflow beyond ACCW is undefined; callers keep vectors ≤ 2^ACC_GUARD beats.

## Timing
- Reset values:
  - out_valid=0, out_data=0, out_ovf=0, out_beats=0.
  - All stage valids=0, acc=0, first tracker=1.
  - in_ready=1 (combinational from out_valid).
- Latency: a last beat accepted at edge N gives out_valid=1 after edge N+3.
- Throughput: one beat per cycle while en=1; back-to-back single-beat vectors give one result per cycle.
- Backpressure:
  - While out_valid && !out_ready, the whole pipeline freezes and in_ready=0.
  - Held out_data, out_ovf and out_beats remain stable.
- On out_valid && out_ready with a new result arriving in S3 the same cycle, the output reloads and out_valid stays 1.
- On out_valid && out_ready with no new result, out_valid falls to 0.
- Beats with in_valid=0 insert bubbles; the accumulator holds and no result is generated.
- Reset asserted mid-vector:
  - Partial sum, in-flight beats and any pending output are discarded.
  - The next accepted beat is treated as first.
- Inputs are sampled only on accepted beats; in_c and in_last on non-accepted cycles are ignored.

## Test plan
- Single beat (defaults): a={1,2,3,4}, b={5,6,7,8}, c=10, last=1 → out_data=80, out_ovf=0, out_beats=1, out_valid exactly 3 cycles after acceptance.
- Two-beat vector: beat 1 a=all 3, b=all 3, c=1; beat 2 a=all -3, b=all 1, c=99 (ignored), last=1 → out_data=25, out_beats=2.
- Saturation: a=all -128, b=all -128, c=0, last=1 → with SATURATE=1, out_data=32767, out_ovf=1; with SATURATE=0, out_data=0, out_ovf=1.
- Backpressure: 8 single-beat vectors with results 1..8, out_ready low for 5 cycles mid-stream → in_ready=0 while stalled; results delivered 1..8 in order with no loss or duplication; held out_data stable.
- Reset mid-vector: 2 beats of a 3-beat vector (each sum 10), assert rst one cycle, then a single-beat vector sum 7, c=0 → out_valid=0 during and after reset; next result=7, out_beats=1.
- Streaming: 16 back-to-back single-beat vectors with out_ready=1 → out_valid high for 16 consecutive cycles, correct values, in_ready never drops.
